// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues one 4-byte fetch per cycle into a
// 1-cycle synchronous-read memory and buffers returned words for decode via valid/ready.
module fetch_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_pc,
    input  logic [31:0]     imem_instr,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    logic [XLEN-1:0] pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic [31:0]     q_instr [QDEPTH];
    logic [XLEN-1:0] q_pc    [QDEPTH];

    logic            deq;
    logic            enq;
    logic            issue;
    logic [CW:0]     occupancy;
    logic [1:0]      unused_redirect_low;

    assign unused_redirect_low = redirect_pc[1:0];

    assign imem_pc  = pc;
    assign if_valid = (count != '0);
    assign deq      = if_valid && if_ready;
    assign enq      = inflight && !redirect;

    // Slots committed after this edge: buffered + in flight, minus the one decode takes now.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq};
    assign issue     = !redirect && (occupancy < {1'b0, DEPTH_C});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (redirect) begin
            pc       <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= pc;
                pc          <= pc + XLEN'(4);
            end else begin
                inflight <= 1'b0;
            end
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; count gates every read, so its contents never leak.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_instr[tail] <= imem_instr;
            q_pc[tail]    <= inflight_pc;
        end
    end

    assign if_instr    = if_valid ? q_instr[head] : '0;
    assign if_pc       = if_valid ? q_pc[head] : '0;
    assign if_pc_plus4 = if_valid ? (q_pc[head] + XLEN'(4)) : '0;

    count_bounded: assert property (@(posedge clk) disable iff (reset) count <= DEPTH_C);

endmodule
